// File: rtl/fft_engine_param.sv
// fft_engine_param: memory-based radix-2 DIT complex FFT/IFFT engine, N = 2^LOG2N.
// A frame is loaded in bit-reversed order, transformed in place over LOG2N
// stages (one butterfly issued per cycle, 1/2 scaling per stage), then streamed
// out in natural order.
// Ports:
//   Clk, Reset            clock, async active-high reset
//   start, inverse        frame start (IDLE only); inverse selects IFFT
//   busy, done            not-IDLE flag; one-cycle pulse after the final output
//   in_valid/in_ready/in_re/in_im         input sample stream
//   out_valid/out_ready/out_re/out_im/out_last  output bin stream
//   tw_addr, tw_re, tw_im twiddle ROM port, data returns one cycle after addr
module fft_engine_param #(
    parameter int WIDTH  = 16,
    parameter int LOG2N  = 8,
    parameter int FRAC   = 14,
    parameter int PE_LAT = 2
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    start,
    input  logic                    inverse,
    output logic                    busy,
    output logic                    done,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_re,
    input  logic signed [WIDTH-1:0] in_im,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_re,
    output logic signed [WIDTH-1:0] out_im,
    output logic                    out_last,
    output logic [LOG2N-2:0]        tw_addr,
    input  logic signed [WIDTH-1:0] tw_re,
    input  logic signed [WIDTH-1:0] tw_im
);
    localparam int N         = 1 << LOG2N;
    localparam int HALF      = N / 2;
    localparam int AW        = LOG2N;
    localparam int TW        = LOG2N - 1;
    localparam int STAGE_LEN = HALF + 1 + PE_LAT;
    localparam int CW        = $clog2(STAGE_LEN);
    localparam int SW        = $clog2(LOG2N + 1);
    localparam int PW        = 2 * WIDTH + 3;
    localparam int BW        = WIDTH + 2;

    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, UNLOAD} state_t;

    typedef struct packed {
        logic [AW-1:0]    a;
        logic [AW-1:0]    b;
        logic [WIDTH-1:0] ar;
        logic [WIDTH-1:0] ai;
        logic [WIDTH-1:0] br;
        logic [WIDTH-1:0] bi;
    } bf_t;

    state_t          state;
    logic            inv_q;
    logic [AW-1:0]   cnt;       // load sample index, then unload bin index
    logic [SW-1:0]   stage;
    logic [CW-1:0]   cyc;       // cycle within the current stage
    logic [PE_LAT:0] vld_pipe;

    logic [WIDTH-1:0] mem_re [N];
    logic [WIDTH-1:0] mem_im [N];

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] x);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) r[i] = x[AW-1-i];
        return r;
    endfunction

    // Butterfly issue addressing: j = cyc during the first HALF cycles of a stage.
    logic          issue;
    logic [TW-1:0] j, mask, k, g;
    logic [AW-1:0] addr_a, addr_b;

    assign issue = (state == COMPUTE) && (cyc < CW'(HALF));

    always_comb begin
        j      = cyc[TW-1:0];
        // At the last stage the shift wraps to 0 and mask becomes all ones (k = j).
        mask   = (TW'(1) << stage) - TW'(1);
        k      = j & mask;
        g      = j >> stage;
        addr_a = ({1'b0, g} << (stage + SW'(1))) | {1'b0, k};
        addr_b = addr_a | (AW'(1) << stage);
        tw_addr = k << (SW'(TW) - stage);
    end

    // Operands captured at issue; twiddle data lines up with them one cycle later.
    bf_t op_q;
    always_ff @(posedge Clk) begin
        op_q.a  <= addr_a;
        op_q.b  <= addr_b;
        op_q.ar <= mem_re[addr_a];
        op_q.ai <= mem_im[addr_a];
        op_q.br <= mem_re[addr_b];
        op_q.bi <= mem_im[addr_b];
    end

    logic signed [PW-1:0] wr, wi, br, bi;
    logic signed [BW-1:0] t_re, t_im, s_ar, s_ai, s_br, s_bi;
    bf_t bf;

    always_comb begin
        wr   = PW'(tw_re);
        wi   = inv_q ? -PW'(tw_im) : PW'(tw_im);
        br   = PW'($signed(op_q.br));
        bi   = PW'($signed(op_q.bi));
        t_re = BW'((wr * br - wi * bi) >>> FRAC);
        t_im = BW'((wr * bi + wi * br) >>> FRAC);
        s_ar = BW'($signed(op_q.ar)) + t_re;
        s_ai = BW'($signed(op_q.ai)) + t_im;
        s_br = BW'($signed(op_q.ar)) - t_re;
        s_bi = BW'($signed(op_q.ai)) - t_im;
        bf    = op_q;
        bf.ar = WIDTH'(s_ar >>> 1);
        bf.ai = WIDTH'(s_ai >>> 1);
        bf.br = WIDTH'(s_br >>> 1);
        bf.bi = WIDTH'(s_bi >>> 1);
    end

    bf_t res_pipe [1:PE_LAT];
    always_ff @(posedge Clk) begin
        res_pipe[1] <= bf;
        for (int i = 2; i <= PE_LAT; i++) res_pipe[i] <= res_pipe[i-1];
    end

    // Load and write-back never overlap, so the two write sources can share the array.
    always_ff @(posedge Clk) begin
        if (state == LOAD && in_valid && in_ready) begin
            mem_re[bitrev(cnt)] <= in_re;
            mem_im[bitrev(cnt)] <= in_im;
        end
        if (vld_pipe[PE_LAT]) begin
            mem_re[res_pipe[PE_LAT].a] <= res_pipe[PE_LAT].ar;
            mem_im[res_pipe[PE_LAT].a] <= res_pipe[PE_LAT].ai;
            mem_re[res_pipe[PE_LAT].b] <= res_pipe[PE_LAT].br;
            mem_im[res_pipe[PE_LAT].b] <= res_pipe[PE_LAT].bi;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            inv_q     <= 1'b0;
            cnt       <= '0;
            stage     <= '0;
            cyc       <= '0;
            vld_pipe  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
        end else begin
            done     <= 1'b0;
            vld_pipe <= {vld_pipe[PE_LAT-1:0], issue};
            case (state)
                IDLE: if (start) begin
                    state    <= LOAD;
                    busy     <= 1'b1;
                    in_ready <= 1'b1;
                    inv_q    <= inverse;
                    cnt      <= '0;
                end
                LOAD: if (in_valid) begin
                    cnt <= cnt + AW'(1);
                    if (cnt == AW'(N - 1)) begin
                        in_ready <= 1'b0;
                        state    <= COMPUTE;
                        stage    <= '0;
                        cyc      <= '0;
                    end
                end
                COMPUTE: begin
                    if (cyc == CW'(STAGE_LEN - 1)) begin
                        // Last write of this stage commits at this edge.
                        cyc <= '0;
                        if (stage == SW'(LOG2N - 1)) begin
                            // Bin 0 was written early in the final stage, so it
                            // can be presented right away.
                            state     <= UNLOAD;
                            stage     <= '0;
                            out_valid <= 1'b1;
                            out_re    <= mem_re[0];
                            out_im    <= mem_im[0];
                            out_last  <= 1'b0;
                            cnt       <= AW'(1);
                        end else begin
                            stage <= stage + SW'(1);
                        end
                    end else begin
                        cyc <= cyc + CW'(1);
                    end
                end
                UNLOAD: if (out_ready) begin
                    if (out_last) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        state     <= IDLE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        cnt       <= '0;
                    end else begin
                        out_re   <= mem_re[cnt];
                        out_im   <= mem_im[cnt];
                        out_last <= (cnt == AW'(N - 1));
                        cnt      <= cnt + AW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
